// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receive FIFO entry type
package uart_pkg;

    // Receiver framing constants
    localparam int UART_DATA_W     = 8;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_STOP_BITS  = 1;

    // Receive FIFO defaults
    localparam int UART_FIFO_DEPTH = 16;
    localparam int UART_ENTRY_W    = UART_DATA_W + 1;

    // One stored byte plus its framing-error tag
    typedef struct packed {
        logic                   err;
        logic [UART_DATA_W-1:0] data;
    } uart_entry_t;

    function automatic uart_entry_t uart_pack_entry(input logic err, input logic [UART_DATA_W-1:0] data);
        uart_entry_t e;
        e.err  = err;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - FIFO storage, one write port, asynchronous read
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [UART_ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]           raddr,
    output logic [UART_ENTRY_W-1:0] rdata
);

    logic [UART_ENTRY_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset; contents only matter behind a valid level
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO with overflow tracking
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = UART_FIFO_DEPTH,
    parameter int AFULL_THRESH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [UART_DATA_W-1:0]   rx_data,
    input  logic                     rx_valid,
    input  logic                     rx_err,
    output logic [UART_DATA_W-1:0]   rd_data,
    output logic                     rd_err,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_L = LW'(AFULL_THRESH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic          pop;
    logic          push;
    logic          drop;
    uart_entry_t   wr_entry;
    uart_entry_t   rd_entry;

    assign pop  = !empty_q && rd_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign push = rx_valid && (!full_q || pop);
    assign drop = rx_valid && full_q && !pop;

    assign wr_entry = uart_pack_entry(rx_err, rx_data);

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push && !rst),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // Next-state for pointers, level, flags and overflow bookkeeping
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end

        // A drop in the same cycle as a clear restarts the count at one
        if (drop) begin
            overflow_d = 1'b1;
            if (ovf_clr) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end

        empty_d = (level_d == '0);
        full_d  = (level_d == DEPTH_L);
        afull_d = (level_d >= AFULL_L);
    end

    // State registers; reset discards all entries and ignores concurrent traffic
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign rd_data     = rd_entry.data;
    assign rd_err      = rd_entry.err;
    assign rd_valid    = !empty_q;
    assign level       = level_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH        (16),
        .AFULL_THRESH (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_err      (rx_err),
        .rd_data     (rd_data),
        .rd_err      (rd_err),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .level       (level),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .ovf_clr     (ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        rx_data  = 8'h00;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic e);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_err   = e;
        step();
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    initial begin
        logic [7:0] exp3 [3];
        exp3[0] = 8'h41;
        exp3[1] = 8'h42;
        exp3[2] = 8'h43;

        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);

        // Three pushes then in-order drain; rd_valid one cycle after first push
        push(8'h41, 1'b0);
        check("lat_rd_valid", rd_valid, 1);
        check("lat_rd_data", rd_data, 8'h41);
        push(8'h42, 1'b0);
        push(8'h43, 1'b0);
        check("three_level", level, 3);
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("order_%0d", i), rd_data, exp3[i]);
            step();
        end
        check("drained_empty", empty, 1);
        step();
        check("ready_on_empty_level", level, 0);
        rd_ready = 1'b0;

        // Fill to 16, almost_full rises at the 12th push
        for (int i = 0; i < 16; i++) begin
            push(8'h10 + 8'(i), 1'b0);
            check($sformatf("afull_push_%0d", i + 1), almost_full, (i + 1 >= 12) ? 1 : 0);
        end
        check("fill_full", full, 1);
        check("fill_level", level, 16);
        push(8'hEE, 1'b0);
        check("drop_overflow", overflow, 1);
        check("drop_cnt_1", drop_cnt, 1);
        check("drop_head", rd_data, 8'h10);
        check("drop_level", level, 16);

        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("clr_overflow", overflow, 0);
        check("clr_drop_cnt", drop_cnt, 0);

        // Simultaneous push and pop while full
        rd_ready = 1'b1;
        push(8'hAB, 1'b0);
        check("simul_level", level, 16);
        check("simul_full", full, 1);
        check("simul_overflow", overflow, 0);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("simul_drain_%0d", i), rd_data, 8'h11 + 8'(i));
            step();
        end
        check("simul_last", rd_data, 8'hAB);
        step();
        check("simul_empty", empty, 1);
        rd_ready = 1'b0;

        // Error tag and head stability under back-pressure
        push(8'h55, 1'b1);
        check("err_rd_err", rd_err, 1);
        check("err_rd_data", rd_data, 8'h55);
        push(8'h66, 1'b0);
        step();
        check("hold_rd_data", rd_data, 8'h55);
        check("hold_rd_err", rd_err, 1);
        rd_ready = 1'b1;
        step();
        check("second_rd_data", rd_data, 8'h66);
        check("second_rd_err", rd_err, 0);
        step();
        rd_ready = 1'b0;
        check("err_empty", empty, 1);

        // Saturating drop count and clear-vs-drop priority
        for (int i = 0; i < 16; i++) begin
            push(8'(i), 1'b0);
        end
        rx_valid = 1'b1;
        rx_data  = 8'hCC;
        for (int i = 0; i < 300; i++) begin
            step();
        end
        check("sat_drop_cnt", drop_cnt, 255);
        check("sat_overflow", overflow, 1);
        check("sat_level", level, 16);
        check("sat_head", rd_data, 8'h00);
        ovf_clr = 1'b1;
        step();
        check("clr_drop_overflow", overflow, 1);
        check("clr_drop_cnt", drop_cnt, 1);
        rx_valid = 1'b0;
        step();
        ovf_clr = 1'b0;
        check("clr_only_overflow", overflow, 0);
        check("clr_only_drop_cnt", drop_cnt, 0);

        // Reset mid-operation at level 5 with overflow set
        push(8'hDD, 1'b0);
        check("pre_rst_overflow", overflow, 1);
        rd_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
        end
        rd_ready = 1'b0;
        check("pre_rst_level", level, 5);
        rst      = 1'b1;
        rx_valid = 1'b1;
        rd_ready = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        check("mid_rst_level", level, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_rd_valid", rd_valid, 0);
        step();
        check("post_rst_level", level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter: DEPTH, 16, entry count (power of two, >=2).
REQ-002 SHALL have parameter: AFULL_THRESH, 12, almost-full level (1..DEPTH).
REQ-003 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port: rx_data  in  8  received byte from UART receiver.
REQ-006 SHALL have port: rx_valid  in  1  one-cycle strobe: rx_data/rx_err valid.
REQ-007 SHALL have port: rx_err  in  1  framing-error tag for the strobed byte.
REQ-008 SHALL have port: rd_data  out  8  head-entry byte.
REQ-009 SHALL have port: rd_err  out  1  head-entry error tag.
REQ-010 SHALL have port: rd_valid  out  1  head entry present (equals !empty).
REQ-011 SHALL have port: rd_ready  in  1  consumer accepts head.
REQ-012 SHALL have port: level  out  clog2(DEPTH)+1  stored-entry count.
REQ-013 SHALL have ports: empty, full, almost_full  out  1 each  status flags.
REQ-014 SHALL have port: overflow  out  1  sticky byte-dropped flag.
REQ-015 SHALL have port: drop_cnt  out  8  saturating dropped-byte count.
REQ-016 SHALL have port: ovf_clr  in  1  clears overflow and drop_cnt.

Function
REQ-017 SHALL be first-word-fall-through: rd_data/rd_err show the oldest entry whenever rd_valid=1.
REQ-018 SHALL pop when rd_valid && rd_ready; rd_ready with empty FIFO is ignored.
REQ-019 SHALL push {rx_err,rx_data} when rx_valid && (!full || pop this cycle).
REQ-020 SHALL give write-to-rd_valid latency of 1 cycle; no same-cycle bypass when empty.
REQ-021 SHALL on simultaneous push and pop keep level unchanged, including when full.
REQ-022 SHALL on rx_valid && full && !pop drop the byte, leave contents unchanged, set overflow, increment drop_cnt.
REQ-023 SHALL saturate drop_cnt at 255.
REQ-024 SHALL on ovf_clr clear overflow and drop_cnt next cycle; drop in the same cycle wins (overflow=1, drop_cnt=1).
REQ-025 SHALL wrap read/write pointers modulo DEPTH; level ranges 0..DEPTH exactly.
REQ-026 SHALL drive empty=(level==0), full=(level==DEPTH), almost_full=(level>=AFULL_THRESH), all registered-consistent with level.
REQ-027 SHALL hold rd_data/rd_err stable while rd_valid && !rd_ready.

Reset
REQ-028 SHALL on rst clear pointers; level=0, empty=1, full=0, almost_full=0, rd_valid=0, overflow=0, drop_cnt=0.
REQ-029 SHALL discard all stored entries on rst mid-operation; concurrent rx_valid/rd_ready ignored that cycle.
REQ-030 SHALL leave storage array uninitialised; rd_data/rd_err are don't-care while rd_valid=0.

Structure
REQ-031 SHALL take byte width (8) and default DEPTH from shared package uart_pkg, alongside UART receiver constants.
REQ-032 SHALL place storage in one sub-module uart_fifo_ram (DEPTH x 9, one write port, async read).
REQ-033 SHALL keep pointers, level, flags and overflow logic in uart_rx_fifo.

Verification
REQ-034 SHALL cover: push 0x41,0x42,0x43 (err=0) then rd_ready=1 -> reads 0x41,0x42,0x43 in order, first rd_valid one cycle after first push.
REQ-035 SHALL cover: 16 pushes, no reads -> full=1, level=16, almost_full rose at 12th push; 17th push -> overflow=1, drop_cnt=1, head still first byte.
REQ-036 SHALL cover: full FIFO, rx_valid and rd_ready same cycle -> level stays 16, overflow stays 0, new byte read last.
REQ-037 SHALL cover: push 0x55 with rx_err=1 -> rd_err=1 with rd_data=0x55.
REQ-038 SHALL cover: 300 drops while full -> drop_cnt=255; ovf_clr concurrent with drop -> overflow=1, drop_cnt=1.
REQ-039 SHALL cover: rst asserted with level=5 -> next cycle level=0, empty=1, overflow=0, rd_valid=0.
